// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - MIPS32 decode stage with forwarding, load-use stall and registered ID/EX output
// ID_PERF_CNT_EN adds the o_stall_cnt stall-cycle counter.
`ifndef N_ALU_OP
`define N_ALU_OP        8
`define N_ALU_SEL       3
`define EXE_NOP_OP      8'b00000000
`define EXE_AND_OP      8'b00100100
`define EXE_OR_OP       8'b00100101
`define EXE_XOR_OP      8'b00100110
`define EXE_NOR_OP      8'b00100111
`define EXE_SLL_OP      8'b01111100
`define EXE_SLLV_OP     8'b00000100
`define EXE_SRL_OP      8'b00000010
`define EXE_SRLV_OP     8'b00000110
`define EXE_SRA_OP      8'b00000011
`define EXE_SRAV_OP     8'b00000111
`define EXE_MOVZ_OP     8'b00001010
`define EXE_MOVN_OP     8'b00001011
`define EXE_MFHI_OP     8'b00010000
`define EXE_MTHI_OP     8'b00010001
`define EXE_MFLO_OP     8'b00010010
`define EXE_MTLO_OP     8'b00010011
`define EXE_MULT_OP     8'b00011000
`define EXE_MULTU_OP    8'b00011001
`define EXE_ADD_OP      8'b00100000
`define EXE_ADDU_OP     8'b00100001
`define EXE_SUB_OP      8'b00100010
`define EXE_SUBU_OP     8'b00100011
`define EXE_SLT_OP      8'b00101010
`define EXE_SLTU_OP     8'b00101011
`define EXE_ADDI_OP     8'b01010101
`define EXE_ADDIU_OP    8'b01010110
`define EXE_MUL_OP      8'b10101001
`define EXE_CLZ_OP      8'b10110000
`define EXE_CLO_OP      8'b10110001
`define EXE_RES_NOP     3'b000
`define EXE_RES_LOGIC   3'b001
`define EXE_RES_SHIFT   3'b010
`define EXE_RES_MOVE    3'b011
`define EXE_RES_ARITH   3'b100
`define EXE_RES_MUL     3'b101
`endif

module id_stage_pipe #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int N_FWD   = 2,
  parameter int PC_W    = 32
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
`ifdef ID_PERF_CNT_EN
  output logic [31:0]                o_stall_cnt,
`endif
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [PC_W-1:0]            i_pc,
  input  logic [31:0]                i_inst,
  output logic [RADDR_W-1:0]         o_rf_raddr0,
  output logic [RADDR_W-1:0]         o_rf_raddr1,
  output logic                       o_rf_ren0,
  output logic                       o_rf_ren1,
  input  logic [XLEN-1:0]            i_rf_rdata0,
  input  logic [XLEN-1:0]            i_rf_rdata1,
  input  logic [N_FWD-1:0]           i_fwd_wen,
  input  logic [N_FWD*RADDR_W-1:0]   i_fwd_waddr,
  input  logic [N_FWD*XLEN-1:0]      i_fwd_wdata,
  input  logic                       i_ld_valid,
  input  logic [RADDR_W-1:0]         i_ld_waddr,
  input  logic                       i_flush,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [PC_W-1:0]            o_pc,
  output logic [`N_ALU_OP-1:0]       o_alu_op,
  output logic [`N_ALU_SEL-1:0]      o_alu_sel,
  output logic [XLEN-1:0]            o_op0,
  output logic [XLEN-1:0]            o_op1,
  output logic                       o_reg_wen,
  output logic [RADDR_W-1:0]         o_reg_waddr
);

  logic [5:0]            w_opc, w_funct;
  logic [4:0]            w_rs, w_rt, w_rd, w_sa;
  logic [`N_ALU_OP-1:0]  w_alu_op;
  logic [`N_ALU_SEL-1:0] w_alu_sel;
  logic                  w_ren0, w_ren1, w_wen_dec, w_movn, w_movz, w_wen, w_haz, w_load;
  logic [RADDR_W-1:0]    w_raddr0, w_raddr1, w_waddr;
  logic [XLEN-1:0]       w_imm, w_imm_sx, w_imm_zx, w_op0, w_op1;

  assign w_opc    = i_inst[31:26];
  assign w_rs     = i_inst[25:21];
  assign w_rt     = i_inst[20:16];
  assign w_rd     = i_inst[15:11];
  assign w_sa     = i_inst[10:6];
  assign w_funct  = i_inst[5:0];
  assign w_imm_sx = {{(XLEN-16){i_inst[15]}}, i_inst[15:0]};
  assign w_imm_zx = {{(XLEN-16){1'b0}}, i_inst[15:0]};
  assign w_raddr0 = RADDR_W'(w_rs);
  assign w_raddr1 = RADDR_W'(w_rt);

  always_comb begin
    w_alu_op  = `EXE_NOP_OP;
    w_alu_sel = `EXE_RES_NOP;
    w_ren0    = 1'b0;
    w_ren1    = 1'b0;
    w_wen_dec = 1'b0;
    w_waddr   = RADDR_W'(w_rd);
    w_imm     = '0;
    w_movn    = 1'b0;
    w_movz    = 1'b0;
    case (w_opc)
      6'b000000: begin
        if (w_sa == 5'd0) begin
          // Most R-type ops read rs/rt and write rd; exceptions override below.
          w_ren0 = 1'b1; w_ren1 = 1'b1; w_wen_dec = 1'b1;
          case (w_funct)
            6'b100101: begin w_alu_op = `EXE_OR_OP;   w_alu_sel = `EXE_RES_LOGIC; end
            6'b100100: begin w_alu_op = `EXE_AND_OP;  w_alu_sel = `EXE_RES_LOGIC; end
            6'b100110: begin w_alu_op = `EXE_XOR_OP;  w_alu_sel = `EXE_RES_LOGIC; end
            6'b100111: begin w_alu_op = `EXE_NOR_OP;  w_alu_sel = `EXE_RES_LOGIC; end
            6'b000100: begin w_alu_op = `EXE_SLLV_OP; w_alu_sel = `EXE_RES_SHIFT; end
            6'b000110: begin w_alu_op = `EXE_SRLV_OP; w_alu_sel = `EXE_RES_SHIFT; end
            6'b000111: begin w_alu_op = `EXE_SRAV_OP; w_alu_sel = `EXE_RES_SHIFT; end
            6'b001111: begin w_ren0 = 1'b0; w_wen_dec = 1'b0; end
            6'b010000: begin w_alu_op = `EXE_MFHI_OP; w_alu_sel = `EXE_RES_MOVE; w_ren0 = 1'b0; w_ren1 = 1'b0; end
            6'b010010: begin w_alu_op = `EXE_MFLO_OP; w_alu_sel = `EXE_RES_MOVE; w_ren0 = 1'b0; w_ren1 = 1'b0; end
            6'b010001: begin w_alu_op = `EXE_MTHI_OP; w_ren1 = 1'b0; w_wen_dec = 1'b0; end
            6'b010011: begin w_alu_op = `EXE_MTLO_OP; w_ren1 = 1'b0; w_wen_dec = 1'b0; end
            6'b001011: begin w_alu_op = `EXE_MOVN_OP; w_alu_sel = `EXE_RES_MOVE; w_movn = 1'b1; end
            6'b001010: begin w_alu_op = `EXE_MOVZ_OP; w_alu_sel = `EXE_RES_MOVE; w_movz = 1'b1; end
            6'b101010: begin w_alu_op = `EXE_SLT_OP;  w_alu_sel = `EXE_RES_ARITH; end
            6'b101011: begin w_alu_op = `EXE_SLTU_OP; w_alu_sel = `EXE_RES_ARITH; end
            6'b100000: begin w_alu_op = `EXE_ADD_OP;  w_alu_sel = `EXE_RES_ARITH; end
            6'b100001: begin w_alu_op = `EXE_ADDU_OP; w_alu_sel = `EXE_RES_ARITH; end
            6'b100010: begin w_alu_op = `EXE_SUB_OP;  w_alu_sel = `EXE_RES_ARITH; end
            6'b100011: begin w_alu_op = `EXE_SUBU_OP; w_alu_sel = `EXE_RES_ARITH; end
            6'b011000: begin w_alu_op = `EXE_MULT_OP;  w_wen_dec = 1'b0; end
            6'b011001: begin w_alu_op = `EXE_MULTU_OP; w_wen_dec = 1'b0; end
            default:   begin w_ren0 = 1'b0; w_ren1 = 1'b0; w_wen_dec = 1'b0; end
          endcase
        end
        // Shift-immediate forms carry shamt through the op0 immediate path.
        if (i_inst[31:21] == 11'd0) begin
          case (w_funct)
            6'b000000: begin w_alu_op = `EXE_SLL_OP; w_alu_sel = `EXE_RES_SHIFT; w_ren0 = 1'b0; w_ren1 = 1'b1; w_wen_dec = 1'b1; w_imm[4:0] = w_sa; end
            6'b000010: begin w_alu_op = `EXE_SRL_OP; w_alu_sel = `EXE_RES_SHIFT; w_ren0 = 1'b0; w_ren1 = 1'b1; w_wen_dec = 1'b1; w_imm[4:0] = w_sa; end
            6'b000011: begin w_alu_op = `EXE_SRA_OP; w_alu_sel = `EXE_RES_SHIFT; w_ren0 = 1'b0; w_ren1 = 1'b1; w_wen_dec = 1'b1; w_imm[4:0] = w_sa; end
            default: ;
          endcase
        end
      end
      6'b011100: begin
        case (w_funct)
          6'b100000: begin w_alu_op = `EXE_CLZ_OP; w_alu_sel = `EXE_RES_ARITH; w_ren0 = 1'b1; w_wen_dec = 1'b1; end
          6'b100001: begin w_alu_op = `EXE_CLO_OP; w_alu_sel = `EXE_RES_ARITH; w_ren0 = 1'b1; w_wen_dec = 1'b1; end
          6'b000010: begin w_alu_op = `EXE_MUL_OP; w_alu_sel = `EXE_RES_MUL; w_ren0 = 1'b1; w_ren1 = 1'b1; w_wen_dec = 1'b1; end
          default: ;
        endcase
      end
      6'b001101: begin w_alu_op = `EXE_OR_OP;    w_alu_sel = `EXE_RES_LOGIC; w_ren0 = 1'b1; w_wen_dec = 1'b1; w_waddr = RADDR_W'(w_rt); w_imm = w_imm_zx; end
      6'b001100: begin w_alu_op = `EXE_AND_OP;   w_alu_sel = `EXE_RES_LOGIC; w_ren0 = 1'b1; w_wen_dec = 1'b1; w_waddr = RADDR_W'(w_rt); w_imm = w_imm_zx; end
      6'b001110: begin w_alu_op = `EXE_XOR_OP;   w_alu_sel = `EXE_RES_LOGIC; w_ren0 = 1'b1; w_wen_dec = 1'b1; w_waddr = RADDR_W'(w_rt); w_imm = w_imm_zx; end
      6'b001111: begin w_alu_op = `EXE_OR_OP;    w_alu_sel = `EXE_RES_LOGIC; w_ren0 = 1'b1; w_wen_dec = 1'b1; w_waddr = RADDR_W'(w_rt); w_imm = w_imm_zx << 16; end
      6'b001010: begin w_alu_op = `EXE_SLT_OP;   w_alu_sel = `EXE_RES_ARITH; w_ren0 = 1'b1; w_wen_dec = 1'b1; w_waddr = RADDR_W'(w_rt); w_imm = w_imm_sx; end
      6'b001011: begin w_alu_op = `EXE_SLTU_OP;  w_alu_sel = `EXE_RES_ARITH; w_ren0 = 1'b1; w_wen_dec = 1'b1; w_waddr = RADDR_W'(w_rt); w_imm = w_imm_sx; end
      6'b001000: begin w_alu_op = `EXE_ADDI_OP;  w_alu_sel = `EXE_RES_ARITH; w_ren0 = 1'b1; w_wen_dec = 1'b1; w_waddr = RADDR_W'(w_rt); w_imm = w_imm_sx; end
      6'b001001: begin w_alu_op = `EXE_ADDIU_OP; w_alu_sel = `EXE_RES_ARITH; w_ren0 = 1'b1; w_wen_dec = 1'b1; w_waddr = RADDR_W'(w_rt); w_imm = w_imm_sx; end
      default: ;
    endcase
  end

  // Priority: immediate, then $0, then youngest matching forward, then regfile.
  function automatic logic [XLEN-1:0] pick_operand(
    input logic               ren,
    input logic [RADDR_W-1:0] raddr,
    input logic [XLEN-1:0]    rf_data,
    input logic [XLEN-1:0]    imm,
    input logic [N_FWD-1:0]   fwd_wen,
    input logic [N_FWD*RADDR_W-1:0] fwd_waddr,
    input logic [N_FWD*XLEN-1:0]    fwd_wdata
  );
    logic [XLEN-1:0] v;
    v = rf_data;
    for (int k = N_FWD - 1; k >= 0; k--) begin
      if (fwd_wen[k] && (fwd_waddr[k*RADDR_W +: RADDR_W] == raddr)) v = fwd_wdata[k*XLEN +: XLEN];
    end
    if (raddr == '0) v = '0;
    if (!ren) v = imm;
    return v;
  endfunction

  assign w_op0 = pick_operand(w_ren0, w_raddr0, i_rf_rdata0, w_imm, i_fwd_wen, i_fwd_waddr, i_fwd_wdata);
  assign w_op1 = pick_operand(w_ren1, w_raddr1, i_rf_rdata1, w_imm, i_fwd_wen, i_fwd_waddr, i_fwd_wdata);
  assign w_wen = w_movn ? (w_op1 != '0) : (w_movz ? (w_op1 == '0) : w_wen_dec);

  assign w_haz = i_valid & i_ld_valid & (i_ld_waddr != '0) &
                 ((w_ren0 & (w_raddr0 == i_ld_waddr)) | (w_ren1 & (w_raddr1 == i_ld_waddr)));
  assign o_ready     = !w_haz & (!o_valid | i_ready);
  assign w_load      = i_valid & o_ready;
  assign o_rf_raddr0 = w_raddr0;
  assign o_rf_raddr1 = w_raddr1;
  assign o_rf_ren0   = w_ren0;
  assign o_rf_ren1   = w_ren1;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      o_valid     <= 1'b0;
      o_pc        <= '0;
      o_alu_op    <= `EXE_NOP_OP;
      o_alu_sel   <= `EXE_RES_NOP;
      o_op0       <= '0;
      o_op1       <= '0;
      o_reg_wen   <= 1'b0;
      o_reg_waddr <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (!o_valid | i_ready) begin
      o_valid <= w_load;
      if (w_load) begin
        o_pc        <= i_pc;
        o_alu_op    <= w_alu_op;
        o_alu_sel   <= w_alu_sel;
        o_op0       <= w_op0;
        o_op1       <= w_op1;
        o_reg_wen   <= w_wen;
        o_reg_waddr <= w_waddr;
      end
    end
  end

`ifdef ID_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
    end else if ((w_haz | (o_valid & !i_ready)) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - table-driven decode vectors plus stall/hazard/flush/reset sequences
// Checks o_stall_cnt when ID_PERF_CNT_EN is defined.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_pc = '0;
  logic [31:0] i_inst = '0;
  logic [4:0]  o_rf_raddr0, o_rf_raddr1;
  logic        o_rf_ren0, o_rf_ren1;
  logic [31:0] i_rf_rdata0, i_rf_rdata1;
  logic [1:0]  i_fwd_wen = '0;
  logic [9:0]  i_fwd_waddr = '0;
  logic [63:0] i_fwd_wdata = '0;
  logic        i_ld_valid = 1'b0;
  logic [4:0]  i_ld_waddr = '0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_pc;
  logic [7:0]  o_alu_op;
  logic [2:0]  o_alu_sel;
  logic [31:0] o_op0, o_op1;
  logic        o_reg_wen;
  logic [4:0]  o_reg_waddr;
`ifdef ID_PERF_CNT_EN
  logic [31:0] o_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Register file model: register n holds 0xC000_0000 | n.
  assign i_rf_rdata0 = 32'hC000_0000 | {27'd0, o_rf_raddr0};
  assign i_rf_rdata1 = 32'hC000_0000 | {27'd0, o_rf_raddr1};

  id_stage_pipe dut (
    .clk(clk), .i_rst_n(i_rst_n),
`ifdef ID_PERF_CNT_EN
    .o_stall_cnt(o_stall_cnt),
`endif
    .i_valid(i_valid), .o_ready(o_ready), .i_pc(i_pc), .i_inst(i_inst),
    .o_rf_raddr0(o_rf_raddr0), .o_rf_raddr1(o_rf_raddr1), .o_rf_ren0(o_rf_ren0), .o_rf_ren1(o_rf_ren1),
    .i_rf_rdata0(i_rf_rdata0), .i_rf_rdata1(i_rf_rdata1),
    .i_fwd_wen(i_fwd_wen), .i_fwd_waddr(i_fwd_waddr), .i_fwd_wdata(i_fwd_wdata),
    .i_ld_valid(i_ld_valid), .i_ld_waddr(i_ld_waddr), .i_flush(i_flush),
    .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_alu_op(o_alu_op), .o_alu_sel(o_alu_sel),
    .o_op0(o_op0), .o_op1(o_op1), .o_reg_wen(o_reg_wen), .o_reg_waddr(o_reg_waddr)
  );

  typedef struct {
    logic [31:0] inst;
    logic [1:0]  fwen;
    logic [4:0]  fa0, fa1;
    logic [31:0] fd0, fd1;
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] e0, e1;
    logic        wen;
    logic [4:0]  wa;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] op, input logic [31:0] e0, input logic [31:0] e1,
                         input logic wen, input logic [4:0] wa, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'd0, o_valid}, 32'd1);
    chk({tag, ".op"},    {24'd0, o_alu_op}, {24'd0, op});
    chk({tag, ".op0"},   o_op0, e0);
    chk({tag, ".op1"},   o_op1, e1);
    chk({tag, ".wen"},   {31'd0, o_reg_wen}, {31'd0, wen});
    chk({tag, ".waddr"}, {27'd0, o_reg_waddr}, {27'd0, wa});
    chk({tag, ".pc"},    o_pc, pc);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, {31'd0, o_valid}, 32'd0);
    chk({tag, ".op"},    {24'd0, o_alu_op}, 32'd0);
    chk({tag, ".sel"},   {29'd0, o_alu_sel}, 32'd0);
    chk({tag, ".op0"},   o_op0, 32'd0);
    chk({tag, ".op1"},   o_op1, 32'd0);
    chk({tag, ".wen"},   {31'd0, o_reg_wen}, 32'd0);
    chk({tag, ".waddr"}, {27'd0, o_reg_waddr}, 32'd0);
    chk({tag, ".pc"},    o_pc, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h34011100, 2'b00, 5'd0, 5'd0, 32'h0,    32'h0,    8'h25, 3'd1, 32'h00000000, 32'h00001100, 1'b1, 5'd1};
    vecs[1]  = '{32'h00221825, 2'b11, 5'd1, 5'd1, 32'hAAAA, 32'h5555, 8'h25, 3'd1, 32'h0000AAAA, 32'hC0000002, 1'b1, 5'd3};
    vecs[2]  = '{32'h00221825, 2'b10, 5'd1, 5'd1, 32'hAAAA, 32'h5555, 8'h25, 3'd1, 32'h00005555, 32'hC0000002, 1'b1, 5'd3};
    vecs[3]  = '{32'h00002825, 2'b01, 5'd0, 5'd0, 32'hFFFF, 32'h0,    8'h25, 3'd1, 32'h00000000, 32'h00000000, 1'b1, 5'd5};
    vecs[4]  = '{32'h000230C0, 2'b00, 5'd0, 5'd0, 32'h0,    32'h0,    8'h7C, 3'd2, 32'h00000003, 32'hC0000002, 1'b1, 5'd6};
    vecs[5]  = '{32'h3C071234, 2'b00, 5'd0, 5'd0, 32'h0,    32'h0,    8'h25, 3'd1, 32'h00000000, 32'h12340000, 1'b1, 5'd7};
    vecs[6]  = '{32'h2428FFFF, 2'b00, 5'd0, 5'd0, 32'h0,    32'h0,    8'h56, 3'd4, 32'hC0000001, 32'hFFFFFFFF, 1'b1, 5'd8};
    vecs[7]  = '{32'h0022480B, 2'b00, 5'd0, 5'd0, 32'h0,    32'h0,    8'h0B, 3'd3, 32'hC0000001, 32'hC0000002, 1'b1, 5'd9};
    vecs[8]  = '{32'h0022480A, 2'b10, 5'd0, 5'd2, 32'h0,    32'h0,    8'h0A, 3'd3, 32'hC0000001, 32'h00000000, 1'b1, 5'd9};
    vecs[9]  = '{32'h0022480B, 2'b10, 5'd0, 5'd2, 32'h0,    32'h0,    8'h0B, 3'd3, 32'hC0000001, 32'h00000000, 1'b0, 5'd9};
    vecs[10] = '{32'h00220018, 2'b00, 5'd0, 5'd0, 32'h0,    32'h0,    8'h18, 3'd0, 32'hC0000001, 32'hC0000002, 1'b0, 5'd0};
    vecs[11] = '{32'h70205020, 2'b00, 5'd0, 5'd0, 32'h0,    32'h0,    8'hB0, 3'd4, 32'hC0000001, 32'h00000000, 1'b1, 5'd10};
    vecs[12] = '{32'h282B0005, 2'b00, 5'd0, 5'd0, 32'h0,    32'h0,    8'h2A, 3'd4, 32'hC0000001, 32'h00000005, 1'b1, 5'd11};
    vecs[13] = '{32'h00436007, 2'b00, 5'd0, 5'd0, 32'h0,    32'h0,    8'h07, 3'd2, 32'hC0000002, 32'hC0000003, 1'b1, 5'd12};
    vecs[14] = '{32'hCC000000, 2'b00, 5'd0, 5'd0, 32'h0,    32'h0,    8'h00, 3'd0, 32'h00000000, 32'h00000000, 1'b0, 5'd0};
    vecs[15] = '{32'h00006810, 2'b00, 5'd0, 5'd0, 32'h0,    32'h0,    8'h10, 3'd3, 32'h00000000, 32'h00000000, 1'b1, 5'd13};

    step(); step();
    chk_zero("reset");
    i_rst_n = 1'b1;

    // Load-use hazard with a simultaneous forward hit on the same register: stall wins.
    i_valid = 1'b1; i_inst = 32'h00432021; i_pc = 32'h800;
    i_ld_valid = 1'b1; i_ld_waddr = 5'd2;
    i_fwd_wen = 2'b01; i_fwd_waddr = {5'd0, 5'd2}; i_fwd_wdata = {32'h0, 32'h7777};
    #1 chk("haz.ready", {31'd0, o_ready}, 32'd0);
    step();
    chk("haz.bubble", {31'd0, o_valid}, 32'd0);
    i_ld_valid = 1'b0;
    #1 chk("haz.release_ready", {31'd0, o_ready}, 32'd1);
    step();
    chk_out("haz.accept", 8'h21, 32'h7777, 32'hC0000003, 1'b1, 5'd4, 32'h800);
    i_fwd_wen = 2'b00;

    // Downstream backpressure for three cycles: outputs must hold.
    i_ready = 1'b0; i_inst = 32'h34011100; i_pc = 32'h900;
    for (int c = 0; c < 3; c++) begin
      #1 chk("hold.ready", {31'd0, o_ready}, 32'd0);
      step();
      chk_out("hold", 8'h21, 32'h7777, 32'hC0000003, 1'b1, 5'd4, 32'h800);
      chk("hold.sel", {29'd0, o_alu_sel}, 32'd4);
    end
    i_ready = 1'b1;
    #1 chk("hold.release_ready", {31'd0, o_ready}, 32'd1);
    step();
    chk_out("hold.next", 8'h25, 32'h0, 32'h1100, 1'b1, 5'd1, 32'h900);
`ifdef ID_PERF_CNT_EN
    chk("stall_cnt", o_stall_cnt, 32'd4);
`endif

    // Loads to $0, or to a register the instruction only writes, must not stall.
    i_ld_valid = 1'b1; i_ld_waddr = 5'd0; i_inst = 32'h00002825;
    #1 chk("haz.ld_r0", {31'd0, o_ready}, 32'd1);
    i_ld_waddr = 5'd3; i_inst = 32'h34231100;
    #1 chk("haz.dest_only", {31'd0, o_ready}, 32'd1);
    step();
    i_ld_valid = 1'b0;

    // Flush while full with a valid incoming instruction: both discarded.
    i_flush = 1'b1; i_inst = 32'h00002825; i_pc = 32'hA00;
    step();
    chk("flush.valid", {31'd0, o_valid}, 32'd0);
    i_flush = 1'b0; i_valid = 1'b0;
    step();
    chk("flush.dropped", {31'd0, o_valid}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      i_valid     = 1'b1;
      i_inst      = vecs[i].inst;
      i_pc        = 32'h400 + 32'(i) * 32'd4;
      i_fwd_wen   = vecs[i].fwen;
      i_fwd_waddr = {vecs[i].fa1, vecs[i].fa0};
      i_fwd_wdata = {vecs[i].fd1, vecs[i].fd0};
      #1 chk($sformatf("vec%0d.ready", i), {31'd0, o_ready}, 32'd1);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].op, vecs[i].e0, vecs[i].e1, vecs[i].wen, vecs[i].wa,
              32'h400 + 32'(i) * 32'd4);
      chk($sformatf("vec%0d.sel", i), {29'd0, o_alu_sel}, {29'd0, vecs[i].sel});
    end
    i_fwd_wen = 2'b00;

    // Reset in the middle of a stall discards the held result.
    i_ready = 1'b0; i_inst = 32'h00221825;
    step();
    i_rst_n = 1'b0;
    step();
    chk_zero("rst_stall");
`ifdef ID_PERF_CNT_EN
    chk("stall_cnt.rst", o_stall_cnt, 32'd0);
`endif
    i_rst_n = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
